// File: rtl/tx_symbol_upsampler_pkg.sv
// Shared constants, state encoding and symbol mapping for the TX symbol upsampler.
package tx_symbol_upsampler_pkg;

    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned PHASE_W     = 2;
    localparam int unsigned FIFO_DEPTH  = 2;
    localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FIFO_IDX_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam int unsigned PRBS_W      = 9;
    localparam int unsigned PRBS_TAP_HI = 8;
    localparam int unsigned PRBS_TAP_LO = 4;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 9'h1FF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit 0 maps to +amp, bit 1 to -amp, so the sample sign bit equals the data bit.
    function automatic logic [SAMPLE_W-1:0] map_symbol(input logic b,
                                                        input logic [SAMPLE_W-1:0] amp);
        return b ? (SAMPLE_W'(0) - amp) : amp;
    endfunction

endpackage

// File: rtl/prbs9_gen.sv
// Fibonacci PRBS9 (x^9 + x^5 + 1); o_bit is the register MSB, advanced on i_enable.
module prbs9_gen
    import tx_symbol_upsampler_pkg::*;
(
    input  logic clock,
    input  logic i_reset_n,
    input  logic i_enable,
    output logic o_bit
);

    logic [PRBS_W-1:0] lfsr_q;
    logic [PRBS_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_enable) begin
            lfsr_d = {lfsr_q[PRBS_W-2:0], lfsr_q[PRBS_TAP_HI] ^ lfsr_q[PRBS_TAP_LO]};
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_bit = lfsr_q[PRBS_TAP_HI];

endmodule

// File: rtl/tx_symbol_upsampler.sv
// Symbol source (2-deep bit FIFO or PRBS9), bit-to-symbol mapper and zero-stuffing
// phase FSM producing OS samples per symbol on i_enable ticks.
module tx_symbol_upsampler
    import tx_symbol_upsampler_pkg::*;
#(
    parameter int AMPLITUDE = 64,
    parameter int OS        = 4
) (
    input  logic                clock,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_bit,
    input  logic                i_bit_valid,
    output logic                o_bit_ready,
    input  logic                i_prbs_en,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_valid,
    output logic [PHASE_W-1:0]  o_phase,
    output logic                o_active
);

    localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(OS - 1);
    localparam logic [SAMPLE_W-1:0] AMP        = SAMPLE_W'(AMPLITUDE);

    state_e                  state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [SAMPLE_W-1:0]     sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic [FIFO_DEPTH-1:0]   fifo_q, fifo_d;
    logic [FIFO_CNT_W-1:0]   count_q, count_d;
    logic [FIFO_CNT_W-1:0]   wr_idx;
    logic                    push;
    logic                    pop;
    logic                    prbs_adv;
    logic                    prbs_bit;

    prbs9_gen u_prbs (
        .clock     (clock),
        .i_reset_n (i_reset_n),
        .i_enable  (prbs_adv),
        .o_bit     (prbs_bit)
    );

    assign o_bit_ready = i_reset_n && !i_prbs_en && (count_q < FIFO_CNT_W'(FIFO_DEPTH));
    assign push        = i_bit_valid && o_bit_ready;

    // Phase FSM: a tick in IDLE or after the last phase is a symbol boundary.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        sample_d = sample_q;
        valid_d  = i_enable;
        pop      = 1'b0;
        prbs_adv = 1'b0;
        if (i_enable) begin
            if (state_q == ST_RUN && phase_q != LAST_PHASE) begin
                phase_d  = phase_q + PHASE_W'(1);
                sample_d = '0;
            end else begin
                phase_d  = '0;
                sample_d = '0;
                if (i_prbs_en) begin
                    state_d  = ST_RUN;
                    sample_d = map_symbol(prbs_bit, AMP);
                    prbs_adv = 1'b1;
                end else if (count_q != '0) begin
                    state_d  = ST_RUN;
                    sample_d = map_symbol(fifo_q[0], AMP);
                    pop      = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
        end
    end

    // FIFO with head at index 0; pop shifts first so a same-cycle push lands behind it.
    always_comb begin
        fifo_d  = fifo_q;
        count_d = count_q;
        wr_idx  = count_q - FIFO_CNT_W'(pop);
        if (pop) begin
            for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
            fifo_d[FIFO_DEPTH-1] = 1'b0;
        end
        if (push) begin
            fifo_d[FIFO_IDX_W'(wr_idx)] = i_bit;
        end
        count_d = count_q + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            fifo_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            fifo_q   <= fifo_d;
            count_q  <= count_d;
        end
    end

    assign o_sample = sample_q;
    assign o_valid  = valid_q;
    assign o_phase  = phase_q;
    assign o_active = (state_q == ST_RUN);

endmodule

// File: doc/tx_symbol_upsampler.md
TX_SYMBOL_UPSAMPLER -- requirements
Module: tx_symbol_upsampler

Interface
REQ-001 Parameter AMPLITUDE, default 64: magnitude of the transmitted symbol, legal range 1..127.
REQ-002 Parameter OS, default 4: oversampling factor, i.e. samples per symbol; only 4 is supported.
REQ-003 clock  input  1  single system clock; all logic is rising-edge.
REQ-004 i_reset_n  input  1  reset; asynchronous, active-low.
REQ-005 i_enable  input  1  sample-rate tick; state advances only on cycles with i_enable=1.
REQ-006 i_bit  input  1  external data bit.
REQ-007 i_bit_valid  input  1  i_bit is valid this cycle.
REQ-008 o_bit_ready  output  1  block accepts i_bit this cycle.
REQ-009 i_prbs_en  input  1  1 = internal PRBS9 is the symbol source; 0 = external bit FIFO.
REQ-010 o_sample  output  8  signed sample to the TX FIR.
REQ-011 o_valid  output  1  one-cycle strobe: o_sample updated this cycle.
REQ-012 o_phase  output  2  phase index of the current o_sample; 0 = symbol peak.
REQ-013 o_active  output  1  high while the state machine is in RUN.

Function
REQ-014 The FIFO shall hold 2 entries; o_bit_ready = (count<2) && !i_prbs_en.
- A push occurs when i_bit_valid && o_bit_ready.
REQ-015 Simultaneous push and pop shall leave count unchanged and preserve FIFO order.
REQ-016 Bit-to-symbol mapping: bit 0 -> +AMPLITUDE, bit 1 -> -AMPLITUDE.
- Result is 8-bit two's complement, so sign bit = data bit.
REQ-017 The state machine shall have two states, IDLE and RUN.
- IDLE: phase held at 0, output samples are 0.
- RUN: phase counts 0,1,2,3,0,... once per i_enable tick.
REQ-018 IDLE->RUN on an i_enable tick when (FIFO non-empty || i_prbs_en).
- That same tick is phase 0 and consumes a symbol.
REQ-019 RUN->IDLE on the i_enable tick following phase 3 when FIFO empty && !i_prbs_en.
- That tick emits 0 with phase 0.
- o_active falls in the same cycle o_valid is asserted for that sample.
REQ-020 On a phase-0 tick in RUN, o_sample shall be the mapped symbol; phases 1..3 shall emit 0 (zero-stuffing).
REQ-021 i_prbs_en shall be sampled only on phase-0 ticks; a change mid-symbol takes effect at the next symbol boundary.
REQ-022 In PRBS mode the FIFO shall not be popped.
- FIFO contents are retained and resume when i_prbs_en returns to 0.
REQ-023 PRBS9 generator:
- polynomial x^9+x^5+1, Fibonacci form;
- output bit = reg[8]; feedback = reg[8]^reg[4] shifted into reg[0];
- advances only on phase-0 ticks in PRBS mode.
REQ-024 Latency:
- o_sample, o_phase and o_valid are registered;
- o_valid=1 exactly one clock after each i_enable=1 cycle, 0 otherwise;
- o_sample and o_phase hold between strobes.
REQ-025 A FIFO pop on a phase-0 tick and an external push in the same cycle shall both succeed when count was 1.

Reset
REQ-026 While i_reset_n=0, all state shall clear asynchronously:
- o_sample=0, o_valid=0, o_phase=0, o_active=0;
- FIFO empty, state IDLE, PRBS register=9'h1FF.
REQ-027 o_bit_ready shall be 0 during reset.
REQ-028 Reset asserted mid-symbol shall discard the FIFO and partial symbol; the first tick after release behaves per REQ-018.

Structure
REQ-029 A shared package shall hold: state encoding (IDLE, RUN), PRBS9 seed 9'h1FF, tap positions, FIFO depth 2, phase width 2.
REQ-030 PRBS9 shall be a sub-module named prbs9_gen with ports clock, i_reset_n, i_enable, o_bit.
REQ-031 The FIFO, mapper and phase FSM shall live in tx_symbol_upsampler.

Verification
REQ-032 Push bits 0,1; i_enable every 4th clock, AMPLITUDE=64 -> o_sample sequence 64,0,0,0,-64,0,0,0, then 0 with o_active=0; o_phase 0,1,2,3 repeating.
REQ-033 Drive i_bit_valid=1 continuously with no i_enable -> exactly 2 pushes accepted, o_bit_ready=0 thereafter; one phase-0 tick -> o_bit_ready=1 the following cycle.
REQ-034 i_prbs_en=1 after reset -> first 9 phase-0 samples = -64 (seed all ones); the PRBS sequence repeats with period 511 symbols.
REQ-035 Toggle i_prbs_en at phase 2 with 1 bit queued -> switch takes effect at the next phase 0; the FIFO bit is emitted later, unchanged.
REQ-036 Assert i_reset_n=0 between clock edges during phase 1 -> outputs 0 immediately, no clock edge required; after release with FIFO empty -> state stays IDLE, o_valid strobes with o_sample=0.
REQ-037 Issue a push in the same cycle as a phase-0 tick with count=1 -> count remains 1; the next symbol is the newly pushed bit.
